// File: rtl/pong_game_ctrl_pkg.sv
// Shared types and constants for the Pong game-state controller.
package pong_game_ctrl_pkg;

  // Game phase; the encoding is also the value of the game_state output.
  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } game_state_t;

  // Highest displayable score; the counter saturates here.
  localparam logic [7:0] SCORE_MAX_BCD = 8'h99;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the game controller and its surroundings.
//
// Handshake: the controller (master) initiates the timer exchange. It drives
// timer_start high for exactly one clk to reload the countdown; the timer
// answers with timer_up, a level that may still be high from an earlier
// expiry, so the controller only trusts it from the cycle after timer_start.
// All other inputs are frame/game events sampled on the rising clk edge.
interface pong_game_ctrl_if;
  import pong_game_ctrl_pkg::*;

  logic        refr_tick;
  logic [1:0]  btn;
  logic        hit;
  logic        miss;
  logic        timer_up;
  logic        timer_start;
  logic        timer_tick;
  logic        gra_still;
  game_state_t game_state;
  logic [7:0]  score_bcd;
  logic [2:0]  balls;
  logic        armed;      // debug view of the timer arming flag

  modport master (
    input  refr_tick, btn, hit, miss, timer_up,
    output timer_start, timer_tick, gra_still, game_state, score_bcd, balls,
           armed
  );

  modport slave (
    output refr_tick, btn, hit, miss, timer_up,
    input  timer_start, timer_tick, gra_still, game_state, score_bcd, balls,
           armed
  );
endinterface

// File: rtl/pong_game_ctrl_bcd_score_counter.sv
// Two-digit BCD score counter that saturates at 99.
module bcd_score_counter
  import pong_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic w_at_max;

  assign w_at_max = ({dig1, dig0} == SCORE_MAX_BCD);

  // Clear wins over increment; units wrap 9->0 with a carry into tens.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig1 <= 4'd0;
      dig0 <= 4'd0;
    end else if (clr) begin
      dig1 <= 4'd0;
      dig0 <= 4'd0;
    end else if (inc && !w_at_max) begin
      if (dig0 == 4'd9) begin
        dig0 <= 4'd0;
        dig1 <= dig1 + 4'd1;
      end else begin
        dig0 <= dig0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-state controller: phase FSM, ball count, timer arming and score.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned LIVES = 3
) (
  input  logic              clk,
  input  logic              reset,
  pong_game_ctrl_if.master  bus
);

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

  game_state_t r_state;
  logic        r_gra_still;
  logic        r_timer_start;
  logic        r_timer_tick;
  logic        r_armed;
  logic [2:0]  r_balls;

  logic        w_btn_any;
  logic        w_score_clr;
  logic        w_score_inc;
  logic [3:0]  w_dig1;
  logic [3:0]  w_dig0;

  assign w_btn_any   = |bus.btn;
  assign w_score_clr = (r_state == NEWGAME) && w_btn_any;
  assign w_score_inc = (r_state == PLAY) && bus.hit;

  bcd_score_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (w_score_clr),
    .inc   (w_score_inc),
    .dig1  (w_dig1),
    .dig0  (w_dig0)
  );

  // Phase FSM with registered outputs, ball counter and timer arming.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= NEWGAME;
      r_gra_still   <= 1'b1;
      r_timer_start <= 1'b0;
      r_timer_tick  <= 1'b0;
      r_armed       <= 1'b0;
      r_balls       <= LIVES_INIT;
    end else begin
      r_timer_tick  <= bus.refr_tick;
      r_timer_start <= 1'b0;
      // A stale timer_up is ignored until the reload pulse has gone out.
      if (r_timer_start) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        NEWGAME: begin
          if (w_btn_any) begin
            r_state     <= PLAY;
            r_gra_still <= 1'b0;
            r_balls     <= LIVES_INIT;
          end
        end
        PLAY: begin
          if (bus.miss) begin
            r_gra_still   <= 1'b1;
            r_timer_start <= 1'b1;
            r_armed       <= 1'b0;
            if (r_balls > 3'd1) begin
              r_balls <= r_balls - 3'd1;
              r_state <= NEWBALL;
            end else begin
              r_balls <= 3'd0;
              r_state <= OVER;
            end
          end
        end
        NEWBALL: begin
          if (r_armed && bus.timer_up && w_btn_any) begin
            r_state     <= PLAY;
            r_gra_still <= 1'b0;
          end
        end
        OVER: begin
          if (r_armed && bus.timer_up) begin
            r_state <= NEWGAME;
          end
        end
        default: begin
          r_state     <= NEWGAME;
          r_gra_still <= 1'b1;
        end
      endcase
    end
  end

  assign bus.timer_start = r_timer_start;
  assign bus.timer_tick  = r_timer_tick;
  assign bus.gra_still   = r_gra_still;
  assign bus.game_state  = r_state;
  assign bus.score_bcd   = {w_dig1, w_dig0};
  assign bus.balls       = r_balls;
  assign bus.armed       = r_armed;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl.
module tb_pong_game_ctrl;
  import pong_game_ctrl_pkg::*;

  localparam int W = 16;  // {state[2], gra_still, balls[3], score[8], timer_start, timer_tick}

  logic clk;
  logic reset;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(.LIVES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic drive(input logic [1:0] b, input logic h, input logic m,
                       input logic tu, input logic rt);
    bus.btn       = b;
    bus.hit       = h;
    bus.miss      = m;
    bus.timer_up  = tu;
    bus.refr_tick = rt;
  endtask

  task automatic push_exp(input string nm, input logic [1:0] st, input logic gra,
                          input logic [2:0] bl, input logic [7:0] sc,
                          input logic ts, input logic tt);
    exp_q.push_back({st, gra, bl, sc, ts, tt});
    name_q.push_back(nm);
  endtask

  task automatic tick_expect(input string nm, input logic [1:0] st, input logic gra,
                             input logic [2:0] bl, input logic [7:0] sc,
                             input logic ts, input logic tt);
    @(posedge clk);
    #1;
    push_exp(nm, st, gra, bl, sc, ts, tt);
  endtask

  function automatic logic [7:0] bcd_of(input int n);
    int v;
    v = (n > 99) ? 99 : n;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Scoreboard monitor: one expectation per falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {bus.game_state, bus.gra_still, bus.balls, bus.score_bcd,
            bus.timer_start, bus.timer_tick};
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%b still=%b balls=%0d score=%h ts=%b tt=%b, want st=%b still=%b balls=%0d score=%h ts=%b tt=%b",
                 nm, g[15:14], g[13], g[12:10], g[9:2], g[1], g[0],
                 e[15:14], e[13], e[12:10], e[9:2], e[1], e[0]);
      end
    end
  end

  // Stimulus
  initial begin
    reset = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset_values", 2'b00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Start a game
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("start_play", 2'b01, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Score up to 12, then on to saturation
    for (int i = 1; i <= 105; i++) begin
      drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 12)
        tick_expect("score_12", 2'b01, 1'b0, 3'd3, 8'h12, 1'b0, 1'b0);
      else
        tick_expect("score_count", 2'b01, 1'b0, 3'd3, bcd_of(i), 1'b0, 1'b0);
    end

    // Miss with 3 balls, stale timer_up held high and button held
    drive(2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    tick_expect("miss_to_newball", 2'b10, 1'b1, 3'd2, 8'h99, 1'b1, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("stale_up_ignored", 2'b10, 1'b1, 3'd2, 8'h99, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("nb_waiting", 2'b10, 1'b1, 3'd2, 8'h99, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("nb_needs_btn", 2'b10, 1'b1, 3'd2, 8'h99, 1'b0, 1'b0);
    drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("nb_to_play", 2'b01, 1'b0, 3'd2, 8'h99, 1'b0, 1'b0);

    // Second miss, events in NEWBALL are ignored
    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_expect("miss2", 2'b10, 1'b1, 3'd1, 8'h99, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("nb2_hold", 2'b10, 1'b1, 3'd1, 8'h99, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_expect("nb2_ignore_hit_miss", 2'b10, 1'b1, 3'd1, 8'h99, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("nb2_to_play", 2'b01, 1'b0, 3'd1, 8'h99, 1'b0, 1'b0);

    // Last ball lost -> OVER, stale timer_up held
    drive(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick_expect("miss_to_over", 2'b11, 1'b1, 3'd0, 8'h99, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("over_stale_up", 2'b11, 1'b1, 3'd0, 8'h99, 1'b0, 1'b0);
    tick_expect("over_to_newgame", 2'b00, 1'b1, 3'd0, 8'h99, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("newgame_holds_score", 2'b00, 1'b1, 3'd0, 8'h99, 1'b0, 1'b0);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("restart", 2'b01, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0);

    // Get to balls=2, score 09
    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick_expect("miss3", 2'b10, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("nb3_hold", 2'b10, 1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    drive(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_expect("nb3_to_play", 2'b01, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      drive(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_expect("score_to_09", 2'b01, 1'b0, 3'd2, bcd_of(i), 1'b0, 1'b0);
    end

    // Simultaneous hit and miss at score 09
    drive(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    tick_expect("hit_and_miss", 2'b10, 1'b1, 3'd1, 8'h10, 1'b1, 1'b0);
    tick_expect("nb4_ignore_1", 2'b10, 1'b1, 3'd1, 8'h10, 1'b0, 1'b0);
    tick_expect("nb4_ignore_2", 2'b10, 1'b1, 3'd1, 8'h10, 1'b0, 1'b0);

    // Frame tick passes through one clk later
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    tick_expect("timer_tick_on", 2'b10, 1'b1, 3'd1, 8'h10, 1'b0, 1'b1);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_expect("timer_tick_off", 2'b10, 1'b1, 3'd1, 8'h10, 1'b0, 1'b0);

    // Asynchronous reset mid-NEWBALL
    @(posedge clk);
    #3;
    reset = 1'b1;
    push_exp("async_reset", 2'b00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    drive(2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    tick_expect("reset_held_1", 2'b00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    tick_expect("reset_held_2", 2'b00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick_expect("after_reset", 2'b00, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0);

    // Drain the scoreboard
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game-state controller for the Pong design. It sequences new-game, play, new-ball and game-over phases, freezes graphics outside play, and keeps the BCD score and remaining-ball count. It drives the countdown timer (`timer_start`/`timer_tick`) and consumes its `timer_up`. The controller is the initiating end of the timer handshake and sits between the frame-tick source, ball/paddle graphics logic and the text overlay.

## Interface
- `LIVES`, 3: balls per game; legal range 1..7.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `refr_tick`  in  1  one-cycle pulse per frame (60 Hz).
- `btn`  in  2  paddle buttons, level; any bit high counts as a press.
- `hit`  in  1  one-cycle pulse: ball struck paddle.
- `miss`  in  1  one-cycle pulse: ball passed paddle.
- `timer_up`  in  1  countdown expired (level, from the timer).
- `timer_start`  out  1  one-cycle timer reload pulse.
- `timer_tick`  out  1  timer decrement strobe.
- `gra_still`  out  1  1 = freeze ball/paddle graphics.
- `game_state`  out  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
- `score_bcd`  out  8  [7:4] tens digit, [3:0] units digit, BCD.
- `balls`  out  3  balls remaining, including the one in play.

## Operation
- FSM states: NEWGAME, PLAY, NEWBALL, OVER.
- NEWGAME:
  - `gra_still`=1.
  - `btn`≠0 → PLAY.
  - On this transition, `score_bcd`←00 and `balls`←LIVES.
- PLAY:
  - `gra_still`=0.
  - `hit` increments the score.
  - `miss` with `balls`>1: `balls`−1, then → NEWBALL.
  - `miss` with `balls`==1: `balls`←0, then → OVER.
  - If `hit` and `miss` arrive in the same cycle, both take effect.
- NEWBALL:
  - `gra_still`=1.
  - Armed `timer_up` AND `btn`≠0 → PLAY.
- OVER:
  - `gra_still`=1.
  - Armed `timer_up` → NEWGAME.
- Entry to NEWBALL or OVER issues exactly one `timer_start` pulse.
- `hit` and `miss` are ignored outside PLAY.
- Score arithmetic:
  - The units digit goes 9→0 with a carry into the tens digit.
  - 99 saturates; further `hit` pulses leave it at 99.
  - A digit never holds a value above 9.
- Timer arming:
  - `timer_up` can still be high from a previous expiry when `timer_start` fires.
  - A 1-bit `armed` flag clears on entry to NEWBALL/OVER.
  - The flag sets on the cycle after `timer_start`.
  - `timer_up` is only honoured while `armed`=1.
- Score and `balls` hold their values through OVER and NEWGAME, so the overlay can display them.

## Timing
- Reset values:
  - state NEWGAME, `gra_still`=1, `game_state`=00.
  - `score_bcd`=8'h00, `balls`=LIVES.
  - `timer_start`=0, `timer_tick`=0, `armed`=0.
- All outputs are registered.
- `timer_tick` is `refr_tick` delayed by one clk.
- `timer_start` is high during the first cycle in NEWBALL/OVER, i.e. one clk after the transition edge.
- Earliest legal exit from NEWBALL/OVER is 2 clk after entry. In practice the exit follows timer expiry: 127 ticks, about 2.1 s.
- `hit` pulse → `score_bcd` update visible 1 clk later.
- Transitions are taken on the edge where the qualifying input is sampled. `game_state` and `gra_still` change on that edge.
- Asynchronous reset mid-game returns all state to reset values immediately. No timer pulse is issued.

## Structure
- Shared package holds:
  - state enum `game_state_t` (NEWGAME/PLAY/NEWBALL/OVER codes above).
  - `SCORE_MAX_BCD` = 8'h99.
- Sub-module `bcd_score_counter`:
  - inputs: clk, reset, clr, inc.
  - outputs: dig1, dig0.
  - provides saturating 2-digit BCD counting.
- The FSM, the ball counter and arming stay in `pong_game_ctrl`.

## Test plan
- Reset, then `btn`=01 for 1 clk → PLAY, `gra_still`=0, `score_bcd`=00, `balls`=3.
- 12 `hit` pulses in PLAY → `score_bcd`=8'h12. Continue to 105 total → remains 8'h99. Check for no hex digits (A–F).
- `miss` with `balls`=3 → NEWBALL, `balls`=2, one `timer_start` pulse. With `timer_up` held high from earlier and `btn` held, no exit for 2 clk. Timer expiry + `btn` → PLAY.
- Three misses with LIVES=3 → OVER, `balls`=0. Timer expiry → NEWGAME, score still shown. `btn` → score 00, `balls` 3.
- `hit` and `miss` same cycle at score 09, `balls` 2 → score 10, `balls` 1, NEWBALL. Also verify `hit`/`miss` in NEWBALL change nothing.
- Assert `reset` mid-NEWBALL while the timer is counting → NEWGAME, score 00, `balls`=LIVES, `timer_start` stays 0.
